// File: rtl/ins_line_fill.sv
// ins_line_fill
//   Refills the 256-word instruction buffer from local store, one line
//   (16 x 32-bit words) at a time, on a single-cycle fetch-stage request.
//   Local-store reads use a simple req/ack handshake with data returned in
//   the ack cycle. Each acked word is written into the buffer one cycle later.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   fill_req           request a refill (accepted only in IDLE)
//   fill_base[15:0]    local-store word address of first line (low bits ignored)
//   fill_lines[4:0]    number of lines to load (0 or >16 means 16)
//   flush              branch redirect: abort fill, invalidate buffer
//   fill_busy          fill in progress (FETCH or DONE)
//   fill_done          one-cycle pulse with the final buffer write
//   ls_req/ls_addr     local-store read request and word address
//   ls_ack/ls_rdata    local-store accept and read data (same cycle)
//   buf_we/buf_waddr/buf_wdata   instruction-buffer write port
//   line_valid         per-line valid bitmap
module ins_line_fill #(
    parameter int LINE_WORDS = 16,
    parameter int NUM_LINES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fill_req,
    input  logic [15:0]          fill_base,
    input  logic [4:0]           fill_lines,
    input  logic                 flush,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 ls_req,
    output logic [15:0]          ls_addr,
    input  logic                 ls_ack,
    input  logic [31:0]          ls_rdata,
    output logic                 buf_we,
    output logic [7:0]           buf_waddr,
    output logic [31:0]          buf_wdata,
    output logic [NUM_LINES-1:0] line_valid
);

    localparam int WIDX_W = $clog2(LINE_WORDS);
    localparam int LIDX_W = $clog2(NUM_LINES);
    localparam int CNT_W  = LIDX_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [15:0]           base_q, base_d;
    logic [CNT_W-1:0]      lines_q, lines_d;
    logic [LIDX_W-1:0]     line_idx_q, line_idx_d;
    logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
    logic [NUM_LINES-1:0]  line_valid_q, line_valid_d;
    logic                  we_q, we_d;
    logic [7:0]            waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  ack_ok;
    logic                  last_word;
    logic                  last_line;
    logic [CNT_W-1:0]      lines_dec;

    // An ack in the flush cycle is dropped entirely.
    assign ack_ok    = (state_q == FETCH) && ls_ack && !flush;
    assign last_word = (word_idx_q == WIDX_W'(LINE_WORDS - 1));
    assign last_line = ({1'b0, line_idx_q} == (lines_q - CNT_W'(1)));

    // 0 and out-of-range counts both mean a full buffer refill.
    assign lines_dec = ((fill_lines == 5'd0) || (fill_lines > 5'(NUM_LINES)))
                       ? CNT_W'(NUM_LINES) : CNT_W'(fill_lines);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        lines_d      = lines_q;
        line_idx_d   = line_idx_q;
        word_idx_d   = word_idx_q;
        line_valid_d = line_valid_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (fill_req && !flush) begin
                    state_d      = FETCH;
                    base_d       = fill_base & ~16'(LINE_WORDS - 1);
                    lines_d      = lines_dec;
                    line_valid_d = '0;
                    line_idx_d   = '0;
                    word_idx_d   = '0;
                end
            end
            FETCH: begin
                if (ack_ok) begin
                    we_d       = 1'b1;
                    waddr_d    = 8'({line_idx_q, word_idx_q});
                    wdata_d    = ls_rdata;
                    word_idx_d = word_idx_q + WIDX_W'(1);
                    if (last_word) begin
                        // Registered alongside the write, so the bit rises
                        // in the same cycle as buf_we for word 15.
                        line_valid_d[line_idx_q] = 1'b1;
                        line_idx_d = line_idx_q + LIDX_W'(1);
                        if (last_line) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d      = IDLE;
            line_valid_d = '0;
            line_idx_d   = '0;
            word_idx_d   = '0;
            we_d         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            lines_q      <= '0;
            line_idx_q   <= '0;
            word_idx_q   <= '0;
            line_valid_q <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            lines_q      <= lines_d;
            line_idx_q   <= line_idx_d;
            word_idx_q   <= word_idx_d;
            line_valid_q <= line_valid_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign ls_req     = (state_q == FETCH);
    // Base is line aligned, so adding {line,word} equals base+16*line+word mod 2^16.
    assign ls_addr    = base_q + 16'({line_idx_q, word_idx_q});
    // A write pending from the previous ack is cancelled by a flush in its cycle.
    assign buf_we     = we_q && !flush;
    assign buf_waddr  = waddr_q;
    assign buf_wdata  = wdata_q;
    assign line_valid = line_valid_q;
    assign fill_busy  = (state_q != IDLE);
    assign fill_done  = (state_q == DONE) && !flush;

endmodule

// File: tb/tb_ins_line_fill.sv
module tb_ins_line_fill;

    logic        clk;
    logic        reset;
    logic        fill_req;
    logic [15:0] fill_base;
    logic [4:0]  fill_lines;
    logic        flush;
    logic        fill_busy;
    logic        fill_done;
    logic        ls_req;
    logic [15:0] ls_addr;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        buf_we;
    logic [7:0]  buf_waddr;
    logic [31:0] buf_wdata;
    logic [15:0] line_valid;

    int errors = 0;
    int checks = 0;

    logic [39:0] sb[$];   // {waddr, wdata} expected per buffer write

    ins_line_fill #(.LINE_WORDS(16), .NUM_LINES(16)) dut (
        .clk(clk), .reset(reset), .fill_req(fill_req), .fill_base(fill_base),
        .fill_lines(fill_lines), .flush(flush), .fill_busy(fill_busy),
        .fill_done(fill_done), .ls_req(ls_req), .ls_addr(ls_addr),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .buf_we(buf_we),
        .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .line_valid(line_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {~a, a} ^ 32'h5A5A_0F0F;
    endfunction

    // Outputs sampled 1 time unit after the falling edge.
    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check({tag, "_req"},  {31'b0, ls_req},    32'd0);
            check({tag, "_we"},   {31'b0, buf_we},    32'd0);
            check({tag, "_done"}, {31'b0, fill_done}, 32'd0);
            check({tag, "_busy"}, {31'b0, fill_busy}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'b0, fill_busy},  32'd0);
        check({tag, "_done"},  {31'b0, fill_done},  32'd0);
        check({tag, "_req"},   {31'b0, ls_req},     32'd0);
        check({tag, "_we"},    {31'b0, buf_we},     32'd0);
        check({tag, "_addr"},  {16'b0, ls_addr},    32'd0);
        check({tag, "_waddr"}, {24'b0, buf_waddr},  32'd0);
        check({tag, "_wdata"}, buf_wdata,           32'd0);
        check({tag, "_lv"},    {16'b0, line_valid}, 32'd0);
    endtask

    // ack_mode 0: ack every request cycle; 1: ack on alternate request cycles.
    // flush_k / reset_k: word index at which flush / reset is driven (-1 none).
    // busy_req_c: loop cycle at which a fill_req is injected while busy (-1 none).
    task automatic run_fill(input string tag, input logic [15:0] base_in, input logic [4:0] lines_in,
                            input int ack_mode, input int flush_k, input int reset_k,
                            input int busy_req_c);
        logic [15:0] exp_base;
        logic [15:0] exp_lv;
        logic [15:0] full_lv;
        logic [39:0] e;
        int nlines, total, k, cyc, dones, done_cyc, tog;
        bit stop, ack, fl, rst;
        exp_base = base_in & 16'hFFF0;
        nlines   = (lines_in == 5'd0 || lines_in > 5'd16) ? 16 : int'(lines_in);
        total    = nlines * 16;
        full_lv  = (nlines == 16) ? 16'hFFFF : 16'((1 << nlines) - 1);
        exp_lv   = '0;
        k = 0; cyc = 0; dones = 0; done_cyc = -1; tog = 0; stop = 0;
        sb.delete();

        @(negedge clk);
        fill_req = 1'b1; fill_base = base_in; fill_lines = lines_in;
        @(negedge clk);
        fill_req = 1'b0;

        while (!stop && cyc < 2000) begin
            cyc++;
            ack = 0; fl = 0; rst = 0;
            if (ls_req) begin
                check({tag, "_ls_addr"}, {16'b0, ls_addr}, {16'b0, 16'(exp_base + 16'(k))});
                ack = (ack_mode == 0) || (tog % 2 == 0);
                tog++;
                if (k == flush_k) begin
                    fl = 1; ack = 1;
                end else if (k == reset_k) begin
                    rst = 1;
                end
            end else if (k < total) begin
                check({tag, "_ls_req_gap"}, {31'b0, ls_req}, 32'd1);
            end
            if (cyc == busy_req_c) begin
                fill_req = 1'b1; fill_base = 16'h3000; fill_lines = 5'd4;
            end
            ls_ack   = ack;
            ls_rdata = mem_f(ls_addr);
            flush    = fl;
            reset    = rst;
            if (ack && !fl && !rst) begin
                sb.push_back({8'(k), mem_f(16'(exp_base + 16'(k)))});
                k++;
            end
            #1;
            if (fl) begin
                check({tag, "_flush_we"},   {31'b0, buf_we},    32'd0);
                check({tag, "_flush_done"}, {31'b0, fill_done}, 32'd0);
                sb.delete();
            end else if (buf_we) begin
                if (sb.size() == 0) begin
                    check({tag, "_spurious_we"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_waddr"}, {24'b0, buf_waddr}, {24'b0, e[39:32]});
                    check({tag, "_wdata"}, buf_wdata, e[31:0]);
                    if (e[35:32] == 4'hF) exp_lv[e[39:36]] = 1'b1;
                    check({tag, "_lv"}, {16'b0, line_valid}, {16'b0, exp_lv});
                end
            end
            if (fill_done && !fl) begin
                dones++;
                done_cyc = cyc;
                check({tag, "_lv_done"}, {16'b0, line_valid}, {16'b0, full_lv});
                check({tag, "_busy_done"}, {31'b0, fill_busy}, 32'd1);
            end
            if (fl || rst || fill_done) stop = 1;
            @(negedge clk);
            fill_req = 1'b0; flush = 1'b0; reset = 1'b0; ls_ack = 1'b0;
        end

        if (!stop) check({tag, "_timeout"}, 32'd1, 32'd0);
        if (flush_k < 0 && reset_k < 0) begin
            check({tag, "_dones"}, dones, 1);
            check({tag, "_words"}, k, total);
            check({tag, "_sb_empty"}, sb.size(), 0);
            if (ack_mode == 0) check({tag, "_done_cyc"}, done_cyc, total + 1);
        end
    endtask

    initial begin
        reset = 1'b1; fill_req = 1'b0; fill_base = '0; fill_lines = '0;
        flush = 1'b0; ls_ack = 1'b0; ls_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("rst_init");
        @(negedge clk);
        reset = 1'b0;

        // One line, continuous ack, with a request injected while busy.
        run_fill("one_line", 16'h0100, 5'd1, 0, -1, -1, 5);
        check_idle(4, "after_one");

        // Unaligned base, count 0 -> 16 lines.
        run_fill("full", 16'h0105, 5'd0, 0, -1, -1, -1);
        check_idle(2, "after_full");

        // Address wrap across 0xFFFF, and request coinciding with fill_done.
        run_fill("wrap", 16'hFFF0, 5'd2, 0, -1, -1, 33);
        check_idle(3, "after_wrap");

        // Alternating ack.
        run_fill("toggle", 16'h0200, 5'd1, 1, -1, -1, -1);

        // Out-of-range count with alternating ack.
        run_fill("over16", 16'h0800, 5'd20, 1, -1, -1, -1);

        // Flush at word 7 of line 1.
        run_fill("flush", 16'h0400, 5'd3, 0, 23, -1, -1);
        #1;
        check("post_flush_req",  {31'b0, ls_req},     32'd0);
        check("post_flush_lv",   {16'b0, line_valid}, 32'd0);
        check("post_flush_busy", {31'b0, fill_busy},  32'd0);
        check("post_flush_done", {31'b0, fill_done},  32'd0);
        check("post_flush_we",   {31'b0, buf_we},     32'd0);
        run_fill("refill", 16'h2000, 5'd1, 0, -1, -1, -1);

        // Reset during FETCH.
        run_fill("mid_rst", 16'h0500, 5'd2, 0, -1, 9, -1);
        #1;
        check_all_zero("post_rst");
        check_idle(3, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
